lsu: RTL and testbench
======================

// Module: lsu
// PURPOSE
//  Load/store unit: the initiator side of the data port of the core's 16KB ram.
//  Accepts one LOAD/STORE request at a time from the execute stage.
//  Checks alignment, range and funct3, then drives the ram data port (w_en, u_en, d_addr, d_in, d_size).
//  Waits out the ram's registered read latency and returns a response, or a fault the core turns into a trap.
// PARAMETERS
//  ADDR_W  14  byte-address width of the ram; bytes 0 .. 2**ADDR_W-1 are legal
// PORTS
//  clk          in   1       clock; all state updates on posedge
//  reset        in   1       asynchronous, active-high reset
//  req_valid    in   1       request present
//  req_ready    out  1       lsu can accept (state IDLE)
//  req_store    in   1       1=store, 0=load
//  req_funct3   in   3       RISC-V funct3 (LB/LH/LW/LBU/LHU; SB/SH/SW)
//  req_addr     in   32      byte address (rs1+imm)
//  req_wdata    in   32      store data, right-aligned
//  req_rd       in   5       destination tag, returned unchanged
//  resp_valid   out  1       response present
//  resp_ready   in   1       consumer takes response
//  resp_rdata   out  32      load data, already extended by ram; 0 for stores and faults
//  resp_rd      out  5       tag of completed request
//  resp_fault   out  1       request faulted, no memory access made
//  resp_cause   out  2       01 misaligned, 10 out of range, 11 illegal funct3
//  mem_w_en     out  1       ram write enable
//  mem_u_en     out  1       ram unsigned-load enable
//  mem_d_addr   out  ADDR_W  ram data byte address
//  mem_d_in     out  32      ram store data
//  mem_d_size   out  2       00 byte, 01 half, 10 word
//  mem_d_out    in   32      ram load data, valid the cycle after address is held with w_en=0
// BEHAVIOUR
//  States: IDLE, ACCESS, CAPTURE, RESP. req_ready = (state==IDLE); no accept in other states.
//  Reset (async): state IDLE. All other outputs 0 and all registers 0. req_ready=1.
//  Accept = req_valid & req_ready. On accept, register addr, size=funct3[1:0], u_en=funct3[2], wdata, rd, store.
//  Fault check on accept. Precedence: illegal > misaligned > range.
//   - Illegal funct3: load 011/110/111; store >=011.
//   - Misaligned: half with addr[0]=1; word with addr[1:0]!=0.
//   - Range: addr[31:ADDR_W]!=0.
//  Fault: IDLE->RESP. resp_fault=1 with cause. mem_w_en never asserted.
//  Ok: IDLE->ACCESS. mem_* are registered outputs, stable for the whole ACCESS cycle.
//   - Store: mem_w_en=1 only during ACCESS. ACCESS->RESP.
//   - Load: mem_w_en=0. ACCESS->CAPTURE. At end of CAPTURE, latch mem_d_out into resp_rdata. CAPTURE->RESP.
//  Latency, accept edge to resp_valid high: load 3 cycles, store 2, fault 1.
//  RESP: resp_valid=1. resp_* held stable until resp_valid&resp_ready, then ->IDLE (req_ready=1 next cycle).
//  mem_d_addr/size/u_en/d_in hold their last value outside ACCESS/CAPTURE. mem_w_en is 0 outside ACCESS.
//  mem_d_in = req_wdata unshifted; the ram selects byte/half lanes from d_addr[1:0].
//  Reset mid-operation: immediate IDLE and mem_w_en=0. A store whose ACCESS edge has not occurred is not written.
//  req_valid dropped without accept: no effect. Requests are never queued.
// TESTING
//  1. SW addr 0x100 wdata 0xDEADBEEF, then LW 0x100 -> resp_rdata 0xDEADBEEF. Store resp 2 cycles, load 3.
//  2. SB 0x103 wdata 0x80, then LB 0x103 -> 0xFFFFFF80; LBU 0x103 -> 0x00000080; LW 0x100 -> 0x80ADBEEF.
//  3. LH 0x101 -> fault, cause 01, resp 1 cycle after accept, mem_w_en never 1.
//     SW 0x4000 -> fault, cause 10.
//     Store funct3 011 at 0x102 -> fault, cause 11 (precedence over misaligned).
//  4. resp_ready held 0 for 5 cycles after LW -> resp_valid, rdata, rd stable; req_ready 0; new req_valid ignored.
//  5. Assert reset during ACCESS of SW 0x200 wdata 0x12345678 -> mem_w_en drops at once; LW 0x200 after reset returns old value 0.
//  6. Back-to-back: LHU 0x202 resp_ready=1 always, next req in IDLE cycle -> req_ready high exactly one cycle between requests.

Source files
------------

// File: rtl/lsu.sv
// Load/store unit: accepts one LOAD/STORE at a time, screens it for faults,
// drives the ram data port and returns a response after the ram's read latency.
module lsu #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic [4:0]        resp_rd,
  output logic              resp_fault,
  output logic [1:0]        resp_cause,
  output logic              mem_w_en,
  output logic              mem_u_en,
  output logic [ADDR_W-1:0] mem_d_addr,
  output logic [31:0]       mem_d_in,
  output logic [1:0]        mem_d_size,
  input  logic [31:0]       mem_d_out
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t              r_state;
  logic                r_store;
  logic                r_resp_valid;
  logic [31:0]         r_rdata;
  logic [4:0]          r_rd;
  logic                r_fault;
  logic [1:0]          r_cause;
  logic                r_w_en;
  logic                r_u_en;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_din;
  logic [1:0]          r_size;

  logic                w_accept;
  logic                w_illegal;
  logic                w_misaligned;
  logic                w_range;
  logic [1:0]          w_cause;

  assign w_accept = req_valid && (r_state == IDLE);

  // Fault screening; cause encodes precedence illegal > misaligned > range.
  always_comb begin
    w_illegal    = 1'b0;
    w_misaligned = 1'b0;
    w_range      = |req_addr[31:ADDR_W];
    w_cause      = 2'b00;
    if (req_store)
      w_illegal = (req_funct3 >= 3'b011);
    else
      w_illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
    w_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    if (w_illegal)
      w_cause = 2'b11;
    else if (w_misaligned)
      w_cause = 2'b01;
    else if (w_range)
      w_cause = 2'b10;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_store      <= 1'b0;
      r_resp_valid <= 1'b0;
      r_rdata      <= '0;
      r_rd         <= '0;
      r_fault      <= 1'b0;
      r_cause      <= '0;
      r_w_en       <= 1'b0;
      r_u_en       <= 1'b0;
      r_addr       <= '0;
      r_din        <= '0;
      r_size       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_rd    <= req_rd;
            r_store <= req_store;
            r_rdata <= '0;
            // A faulting request never touches the ram port registers.
            if (w_cause != 2'b00) begin
              r_fault      <= 1'b1;
              r_cause      <= w_cause;
              r_resp_valid <= 1'b1;
              r_state      <= RESP;
            end else begin
              r_fault <= 1'b0;
              r_cause <= 2'b00;
              r_addr  <= req_addr[ADDR_W-1:0];
              r_size  <= req_funct3[1:0];
              r_u_en  <= req_funct3[2];
              r_din   <= req_wdata;
              r_w_en  <= req_store;
              r_state <= ACCESS;
            end
          end
        end
        ACCESS: begin
          r_w_en <= 1'b0;
          if (r_store) begin
            r_resp_valid <= 1'b1;
            r_state      <= RESP;
          end else begin
            r_state <= CAPTURE;
          end
        end
        CAPTURE: begin
          r_rdata      <= mem_d_out;
          r_resp_valid <= 1'b1;
          r_state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready  = (r_state == IDLE);
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_rdata;
  assign resp_rd    = r_rd;
  assign resp_fault = r_fault;
  assign resp_cause = r_cause;
  assign mem_w_en   = r_w_en;
  assign mem_u_en   = r_u_en;
  assign mem_d_addr = r_addr;
  assign mem_d_in   = r_din;
  assign mem_d_size = r_size;

endmodule

// File: tb/tb_lsu.sv
// Testbench for lsu: behavioural ram on the data port plus a byte-array
// reference model that predicts every response, latency and fault cause.
module tb_lsu;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic        resp_fault;
  logic [1:0]  resp_cause;
  logic        mem_w_en;
  logic        mem_u_en;
  logic [13:0] mem_d_addr;
  logic [31:0] mem_d_in;
  logic [1:0]  mem_d_size;
  logic [31:0] mem_d_out;

  int errors = 0;
  int checks = 0;
  int wenCount = 0;

  logic [7:0] ramBytes [0:16383];
  logic [7:0] refMem   [0:16383];

  lsu #(.ADDR_W(14)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_rd(resp_rd), .resp_fault(resp_fault), .resp_cause(resp_cause),
    .mem_w_en(mem_w_en), .mem_u_en(mem_u_en), .mem_d_addr(mem_d_addr),
    .mem_d_in(mem_d_in), .mem_d_size(mem_d_size), .mem_d_out(mem_d_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The ram: byte-lane writes on the clock edge, registered extended reads.
  function automatic logic [31:0] ramRead(logic [13:0] a, logic [1:0] sz, logic u);
    int base;
    logic [31:0] v;
    base = int'(a);
    v = 32'h0;
    case (sz)
      2'b00: v = u ? {24'h0, ramBytes[base]} : {{24{ramBytes[base][7]}}, ramBytes[base]};
      2'b01: v = u ? {16'h0, ramBytes[base+1], ramBytes[base]}
                   : {{16{ramBytes[base+1][7]}}, ramBytes[base+1], ramBytes[base]};
      default: v = {ramBytes[base+3], ramBytes[base+2], ramBytes[base+1], ramBytes[base]};
    endcase
    return v;
  endfunction

  always @(posedge clk) begin
    if (mem_w_en) begin
      wenCount++;
      case (mem_d_size)
        2'b00: ramBytes[int'(mem_d_addr)] <= mem_d_in[7:0];
        2'b01: begin
          ramBytes[int'(mem_d_addr)]   <= mem_d_in[7:0];
          ramBytes[int'(mem_d_addr)+1] <= mem_d_in[15:8];
        end
        default: begin
          ramBytes[int'(mem_d_addr)]   <= mem_d_in[7:0];
          ramBytes[int'(mem_d_addr)+1] <= mem_d_in[15:8];
          ramBytes[int'(mem_d_addr)+2] <= mem_d_in[23:16];
          ramBytes[int'(mem_d_addr)+3] <= mem_d_in[31:24];
        end
      endcase
    end else begin
      mem_d_out <= ramRead(mem_d_addr, mem_d_size, mem_u_en);
    end
  end

  // Reference model: fault rules, load values and store effects from plain arithmetic.
  function automatic logic [1:0] expCause(bit st, logic [2:0] f3, logic [31:0] a);
    bit ill;
    longint nb;
    if (st) ill = (f3 > 3'd2);
    else    ill = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    if (ill) return 2'b11;
    nb = longint'(1) << f3[1:0];
    if ((longint'(a) % nb) != 0) return 2'b01;
    if (a >= 32'd16384) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [31:0] expLoad(logic [2:0] f3, logic [31:0] a);
    longint nb, v;
    nb = longint'(1) << f3[1:0];
    v = 0;
    for (int i = 0; i < nb; i++) v = v + (longint'(refMem[int'(a) + i]) << (8 * i));
    if (!f3[2] && nb < 4 && v >= (longint'(1) << (8 * nb - 1)))
      v = v - (longint'(1) << (8 * nb));
    return v[31:0];
  endfunction

  task automatic refStore(logic [2:0] f3, logic [31:0] a, logic [31:0] wd);
    int nb;
    nb = 1 << f3[1:0];
    for (int i = 0; i < nb; i++) refMem[int'(a) + i] = 8'((wd >> (8 * i)) & 32'hFF);
  endtask

  task automatic checkOutput(string tag, logic [31:0] observed, logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Issues one request, checks latency and response, optionally stalls the response.
  task automatic applyStimulus(bit st, logic [2:0] f3, logic [31:0] a, logic [31:0] wd,
                               logic [4:0] rd, int hold);
    logic [1:0]  cause;
    logic [31:0] expData;
    int          expLat, lat, w0;
    cause   = expCause(st, f3, a);
    expLat  = (cause != 2'b00) ? 1 : (st ? 2 : 3);
    expData = (cause != 2'b00 || st) ? 32'h0 : expLoad(f3, a);
    checkOutput("req_ready_idle", 32'(req_ready), 32'd1);
    w0 = wenCount;
    req_valid = 1'b1; req_store = st; req_funct3 = f3;
    req_addr = a; req_wdata = wd; req_rd = rd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("latency", 32'(lat), 32'(expLat));
    checkOutput("rdata", resp_rdata, expData);
    checkOutput("rd", 32'(resp_rd), 32'(rd));
    checkOutput("fault", 32'(resp_fault), 32'(cause != 2'b00));
    checkOutput("cause", 32'(resp_cause), 32'(cause));
    checkOutput("wen_count", 32'(wenCount - w0), (st && cause == 2'b00) ? 32'd1 : 32'd0);
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010;
      req_addr = 32'h300; req_wdata = 32'hCAFEF00D; req_rd = ~rd;
      @(posedge clk); #1;
      checkOutput("hold_valid", 32'(resp_valid), 32'd1);
      checkOutput("hold_rdata", resp_rdata, expData);
      checkOutput("hold_rd", 32'(resp_rd), 32'(rd));
      checkOutput("hold_req_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    checkOutput("resp_done", 32'(resp_valid), 32'd0);
    checkOutput("ready_after", 32'(req_ready), 32'd1);
    checkOutput("wen_total", 32'(wenCount - w0), (st && cause == 2'b00) ? 32'd1 : 32'd0);
    if (st && cause == 2'b00) refStore(f3, a, wd);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit          st;
    logic [2:0]  f3;
    logic [31:0] a;
    int          r, lat;

    for (int i = 0; i < 16384; i++) begin
      ramBytes[i] = 8'h00;
      refMem[i]   = 8'h00;
    end
    reset = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'h0; resp_ready = 1'b0;
    #23;
    checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
    checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("rst_w_en", 32'(mem_w_en), 32'd0);
    checkOutput("rst_d_addr", 32'(mem_d_addr), 32'd0);
    checkOutput("rst_rdata", resp_rdata, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Directed: word round trip, byte sub-word loads, fault causes, stalled response.
    applyStimulus(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 5'd1, 0);
    applyStimulus(1'b0, 3'b010, 32'h100, 32'h0, 5'd2, 0);
    applyStimulus(1'b1, 3'b000, 32'h103, 32'h00000080, 5'd3, 0);
    applyStimulus(1'b0, 3'b000, 32'h103, 32'h0, 5'd4, 0);
    applyStimulus(1'b0, 3'b100, 32'h103, 32'h0, 5'd5, 0);
    applyStimulus(1'b0, 3'b010, 32'h100, 32'h0, 5'd6, 0);
    checkOutput("t2_model_word", expLoad(3'b010, 32'h100), 32'h80ADBEEF);
    applyStimulus(1'b0, 3'b001, 32'h101, 32'h0, 5'd7, 0);
    applyStimulus(1'b1, 3'b010, 32'h4000, 32'h11111111, 5'd8, 0);
    applyStimulus(1'b1, 3'b011, 32'h102, 32'h22222222, 5'd9, 0);
    applyStimulus(1'b0, 3'b010, 32'h100, 32'h0, 5'd10, 5);

    // Reset while a store sits in ACCESS: the write must never land.
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h200; req_wdata = 32'h12345678; req_rd = 5'd11;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checkOutput("t5_w_en_access", 32'(mem_w_en), 32'd1);
    #2 reset = 1'b1;
    #1;
    checkOutput("t5_w_en_reset", 32'(mem_w_en), 32'd0);
    checkOutput("t5_req_ready", 32'(req_ready), 32'd1);
    checkOutput("t5_d_addr", 32'(mem_d_addr), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    applyStimulus(1'b0, 3'b010, 32'h200, 32'h0, 5'd12, 0);

    // Back-to-back with resp_ready held high.
    applyStimulus(1'b1, 3'b001, 32'h202, 32'h0000A5F0, 5'd13, 0);
    resp_ready = 1'b1;
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b101;
    req_addr = 32'h202; req_rd = 5'd14;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("b2b_lat", 32'(lat), 32'd3);
    checkOutput("b2b_rdata", resp_rdata, expLoad(3'b101, 32'h202));
    @(posedge clk); #1;
    checkOutput("b2b_ready_gap", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_funct3 = 3'b010; req_addr = 32'h100; req_rd = 5'd15;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checkOutput("b2b_ready_busy", 32'(req_ready), 32'd0);
    lat = 1;
    while (!resp_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("b2b_rdata2", resp_rdata, expLoad(3'b010, 32'h100));
    @(posedge clk); #1;
    resp_ready = 1'b0;
    checkOutput("b2b_idle", 32'(req_ready), 32'd1);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 60; n++) begin
      st = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      r  = int'($urandom_range(0, 7));
      if (r == 0) a = $urandom;
      else        a = 32'($urandom_range(0, 16383));
      if (r >= 3) a = a & ~((32'd1 << f3[1:0]) - 32'd1);
      applyStimulus(st, f3, a, $urandom, 5'($urandom_range(0, 31)),
                    int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
